// File: rtl/pl_rst_pkg.sv
// Shared types and constants for the PL reset sequencer: state encoding
// and the saturation limits used by the status counters.
package pl_rst_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    FILTER     = 3'd2,
    ICN_UP     = 3'd3,
    RUN        = 3'd4
  } seq_state_e;

  localparam int              EVT_W   = 8;
  localparam logic [EVT_W-1:0] EVT_MAX = 8'hFF;
  localparam logic [EVT_W-1:0] EVT_ONE = 8'd1;
  localparam int              PHASE_W = 8;

endpackage

// File: rtl/pl_rst_sequencer_if.sv
// Lock/request inputs and reset/status outputs of the PL reset sequencer.
// Level signals only; there is no valid/ready handshake on this bus.
interface pl_rst_sequencer_if #(
  parameter int CNT_W = 32
);
  import pl_rst_pkg::*;

  logic               dcm_locked;
  logic               aux_reset_in;
  logic               interconnect_aresetn;
  logic               peripheral_aresetn;
  logic               peripheral_reset;
  logic               rst_active;
  logic [STATE_W-1:0] seq_state;
  logic [CNT_W-1:0]   run_cycles;
  logic [EVT_W-1:0]   reset_events;

  modport master (
    input  dcm_locked, aux_reset_in,
    output interconnect_aresetn, peripheral_aresetn, peripheral_reset,
    output rst_active, seq_state, run_cycles, reset_events
  );

  modport slave (
    output dcm_locked, aux_reset_in,
    input  interconnect_aresetn, peripheral_aresetn, peripheral_reset,
    input  rst_active, seq_state, run_cycles, reset_events
  );

endinterface

// File: rtl/pl_rst_sync.sv
// Multi-flop synchroniser with asynchronous active-low clear; output is the
// last flop of the chain.
module pl_rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/pl_rst_sequencer.sv
// Ordered PL reset release: interconnect first, peripherals ICN_DELAY cycles
// later, gated by a filtered lock indication; exposes state and counters.
module pl_rst_sequencer
  import pl_rst_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16,
  parameter int ICN_DELAY     = 8,
  parameter int CNT_W         = 32
) (
  input  logic               pl_clk0,
  input  logic               pl_resetn,
  pl_rst_sequencer_if.master bus
);

  localparam logic [PHASE_W-1:0] FILT_LAST = PHASE_W'(FILTER_CYCLES - 1);
  localparam logic [PHASE_W-1:0] DLY_LAST  = PHASE_W'(ICN_DELAY - 1);
  localparam logic [PHASE_W-1:0] PH_ONE    = PHASE_W'(1);
  localparam logic [CNT_W-1:0]   RUN_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   RUN_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic w_rst_ok;
  logic w_locked_s;
  logic w_aux_s;
  logic w_fault;

  seq_state_e         r_state;
  seq_state_e         w_next;
  logic [PHASE_W-1:0] r_filt_cnt;
  logic [PHASE_W-1:0] w_filt_nxt;
  logic [PHASE_W-1:0] r_dly_cnt;
  logic [PHASE_W-1:0] w_dly_nxt;
  logic               w_event;

  logic               w_icn_n_d;
  logic               w_per_n_d;
  logic               r_icn_n;
  logic               r_per_n;
  logic               r_per_rst;
  logic               r_rst_act;
  logic [CNT_W-1:0]   r_run_cycles;
  logic [EVT_W-1:0]   r_reset_events;

  pl_rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
    .i_clk(pl_clk0), .i_rst_n(pl_resetn), .i_d(1'b1), .o_q(w_rst_ok)
  );

  pl_rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .i_clk(pl_clk0), .i_rst_n(pl_resetn), .i_d(bus.dcm_locked), .o_q(w_locked_s)
  );

  pl_rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_aux_sync (
    .i_clk(pl_clk0), .i_rst_n(pl_resetn), .i_d(bus.aux_reset_in), .o_q(w_aux_s)
  );

  assign w_fault = w_aux_s | ~w_locked_s;

  always_ff @(posedge pl_clk0 or negedge pl_resetn) begin
    if (!pl_resetn) begin
      r_state    <= RESET_HOLD;
      r_filt_cnt <= '0;
      r_dly_cnt  <= '0;
    end else begin
      r_state    <= w_next;
      r_filt_cnt <= w_filt_nxt;
      r_dly_cnt  <= w_dly_nxt;
    end
  end

  // Only faults after the interconnect has been released count as events.
  always_comb begin
    w_next     = r_state;
    w_filt_nxt = r_filt_cnt;
    w_dly_nxt  = r_dly_cnt;
    w_event    = 1'b0;
    case (r_state)
      RESET_HOLD: begin
        if (w_rst_ok && !w_aux_s) w_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (w_aux_s) begin
          w_next = RESET_HOLD;
        end else if (w_locked_s) begin
          w_next     = FILTER;
          w_filt_nxt = '0;
        end
      end
      FILTER: begin
        if (w_aux_s) begin
          w_next = RESET_HOLD;
        end else if (!w_locked_s) begin
          w_next = WAIT_LOCK;
        end else if (r_filt_cnt == FILT_LAST) begin
          w_next    = ICN_UP;
          w_dly_nxt = '0;
        end else begin
          w_filt_nxt = r_filt_cnt + PH_ONE;
        end
      end
      ICN_UP: begin
        if (w_fault) begin
          w_next  = RESET_HOLD;
          w_event = 1'b1;
        end else if (r_dly_cnt == DLY_LAST) begin
          w_next = RUN;
        end else begin
          w_dly_nxt = r_dly_cnt + PH_ONE;
        end
      end
      RUN: begin
        if (w_fault) begin
          w_next  = RESET_HOLD;
          w_event = 1'b1;
        end
      end
      default: w_next = RESET_HOLD;
    endcase
  end

  // Reset outputs are decoded from the next state so they change on the
  // same edge as the state transition.
  always_comb begin
    w_icn_n_d = 1'b0;
    w_per_n_d = 1'b0;
    case (w_next)
      ICN_UP:  w_icn_n_d = 1'b1;
      RUN: begin
        w_icn_n_d = 1'b1;
        w_per_n_d = 1'b1;
      end
      default: begin
        w_icn_n_d = 1'b0;
        w_per_n_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pl_clk0 or negedge pl_resetn) begin
    if (!pl_resetn) begin
      r_icn_n        <= 1'b0;
      r_per_n        <= 1'b0;
      r_per_rst      <= 1'b1;
      r_rst_act      <= 1'b1;
      r_run_cycles   <= '0;
      r_reset_events <= '0;
    end else begin
      r_icn_n   <= w_icn_n_d;
      r_per_n   <= w_per_n_d;
      r_per_rst <= ~w_per_n_d;
      r_rst_act <= ~w_per_n_d;
      if (r_state == RUN && r_run_cycles != RUN_MAX) begin
        r_run_cycles <= r_run_cycles + RUN_ONE;
      end
      if (w_event && r_reset_events != EVT_MAX) begin
        r_reset_events <= r_reset_events + EVT_ONE;
      end
    end
  end

  assign bus.interconnect_aresetn = r_icn_n;
  assign bus.peripheral_aresetn   = r_per_n;
  assign bus.peripheral_reset     = r_per_rst;
  assign bus.rst_active           = r_rst_act;
  assign bus.seq_state            = r_state;
  assign bus.run_cycles           = r_run_cycles;
  assign bus.reset_events         = r_reset_events;

endmodule

// File: tb/tb_pl_rst_sequencer.sv
// Bench for pl_rst_sequencer: directed scenarios plus random lock/aux/reset
// stimulus, checked every cycle against a streak-based reference model.
module tb_pl_rst_sequencer;

  localparam int S = 2;
  localparam int F = 16;
  localparam int D = 8;
  localparam int ICN_AT = F + 1;
  localparam int RUN_AT = F + D + 1;

  logic pl_clk0 = 1'b0;
  logic pl_resetn = 1'b1;
  logic dcm_locked = 1'b1;
  logic aux_reset_in = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int edge_no = 0;

  pl_rst_sequencer_if #(.CNT_W(32)) bus ();
  pl_rst_sequencer_if #(.CNT_W(4))  bus4 ();

  assign bus.dcm_locked    = dcm_locked;
  assign bus.aux_reset_in  = aux_reset_in;
  assign bus4.dcm_locked   = dcm_locked;
  assign bus4.aux_reset_in = aux_reset_in;

  pl_rst_sequencer #(.SYNC_STAGES(S), .FILTER_CYCLES(F), .ICN_DELAY(D), .CNT_W(32)) u_dut (
    .pl_clk0(pl_clk0), .pl_resetn(pl_resetn), .bus(bus)
  );

  pl_rst_sequencer #(.SYNC_STAGES(S), .FILTER_CYCLES(F), .ICN_DELAY(D), .CNT_W(4)) u_dut4 (
    .pl_clk0(pl_clk0), .pl_resetn(pl_resetn), .bus(bus4)
  );

  always #5 pl_clk0 = ~pl_clk0;

  // Reference model: a streak of consecutive good edges replaces state and
  // phase counters; synchronisers are plain delay queues.
  bit     m_hold;
  int     m_streak;
  int     m_rel;
  bit     lq[$];
  bit     aq[$];
  longint m_run;
  int     m_evt;

  function automatic void model_reset();
    m_hold = 1'b1;
    m_streak = 0;
    m_rel = 0;
    lq = {};
    aq = {};
    for (int i = 0; i < S; i++) begin
      lq.push_back(1'b0);
      aq.push_back(1'b0);
    end
    m_run = 0;
    m_evt = 0;
  endfunction

  function automatic void model_edge();
    bit l_s, a_s, ok;
    ok  = (m_rel >= S);
    l_s = lq.pop_front();
    a_s = aq.pop_front();
    lq.push_back(dcm_locked);
    aq.push_back(aux_reset_in);
    if (m_rel < S) m_rel++;
    if (!m_hold && m_streak >= RUN_AT) m_run++;
    if (m_hold) begin
      if (ok && !a_s) begin
        m_hold = 1'b0;
        m_streak = 0;
      end
    end else if (a_s || !l_s) begin
      if (m_streak >= ICN_AT) begin
        m_hold = 1'b1;
        if (m_evt < 255) m_evt++;
      end else if (a_s) begin
        m_hold = 1'b1;
      end else begin
        m_streak = 0;
      end
    end else if (m_streak < RUN_AT) begin
      m_streak++;
    end
  endfunction

  function automatic int m_state();
    if (m_hold) return 0;
    if (m_streak == 0) return 1;
    if (m_streak <= F) return 2;
    if (m_streak < RUN_AT) return 3;
    return 4;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    bit icn, per;
    longint r4;
    icn = !m_hold && m_streak >= ICN_AT;
    per = !m_hold && m_streak >= RUN_AT;
    r4  = (m_run > 15) ? 15 : m_run;
    check("icn",    bus.interconnect_aresetn, icn);
    check("per",    bus.peripheral_aresetn, per);
    check("prst",   bus.peripheral_reset, !per);
    check("active", bus.rst_active, !per);
    check("state",  bus.seq_state, m_state());
    check("run",    bus.run_cycles, m_run);
    check("evt",    bus.reset_events, m_evt);
    check("icn4",   bus4.interconnect_aresetn, icn);
    check("state4", bus4.seq_state, m_state());
    check("run4",   bus4.run_cycles, r4);
    check("evt4",   bus4.reset_events, m_evt);
  endtask

  task automatic step();
    @(posedge pl_clk0);
    if (pl_resetn) begin
      model_edge();
      edge_no++;
    end
    @(negedge pl_clk0);
    check_all();
  endtask

  task automatic do_reset();
    pl_resetn = 1'b0;
    model_reset();
    #1;
    check_all();
  endtask

  task automatic release_rst();
    repeat (2) step();
    pl_resetn = 1'b1;
    edge_no = 0;
  endtask

  task automatic run_until(input int st, input int budget, input string tag);
    int n;
    n = 0;
    while (m_state() != st && n < budget) begin
      step();
      n++;
    end
    check(tag, bus.seq_state, st);
  endtask

  int st_at[0:63];
  int icn_rise, per_rise, prst_fall, cnt;

  initial begin
    model_reset();
    #2;
    // Scenario 1: locked before release, nominal timing.
    do_reset();
    check("rst_icn", bus.interconnect_aresetn, 0);
    check("rst_prst", bus.peripheral_reset, 1);
    release_rst();
    icn_rise = 0; per_rise = 0; prst_fall = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      st_at[edge_no] = int'(bus.seq_state);
      if (icn_rise == 0 && bus.interconnect_aresetn) icn_rise = edge_no;
      if (per_rise == 0 && bus.peripheral_aresetn) per_rise = edge_no;
      if (prst_fall == 0 && !bus.peripheral_reset) prst_fall = edge_no;
      if (edge_no == 29) check("run_e29", bus.run_cycles, 1);
    end
    check("icn_edge", icn_rise, S + 2 + F);
    check("per_edge", per_rise, S + 2 + F + D);
    check("prst_edge", prst_fall, S + 2 + F + D);
    check("st_e2", st_at[2], 0);
    check("st_e3", st_at[3], 1);
    check("st_e4", st_at[4], 2);
    check("st_e19", st_at[19], 2);
    check("st_e20", st_at[20], 3);
    check("st_e27", st_at[27], 3);
    check("st_e28", st_at[28], 4);

    // Scenario 2: lock arrives 40 cycles after release.
    do_reset();
    dcm_locked = 1'b0;
    release_rst();
    repeat (40) step();
    dcm_locked = 1'b1;
    cnt = 0;
    while (!bus.interconnect_aresetn && cnt < 100) begin
      step();
      cnt++;
    end
    check("late_lock_edges", cnt, F + S + 1);
    check("late_lock_evt", bus.reset_events, 0);

    // Scenario 3: one-cycle lock glitch at filt_cnt=10.
    do_reset();
    release_rst();
    repeat (S + 2 + 10) step();
    dcm_locked = 1'b0;
    step();
    dcm_locked = 1'b1;
    icn_rise = 0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (icn_rise == 0 && bus.interconnect_aresetn) icn_rise = edge_no;
      if (icn_rise == 0 && !bus.rst_active) cnt++;
    end
    check("glitch_icn_edge", icn_rise, (S + 2 + 10) + S + 2 + F);
    check("glitch_no_release", cnt, 0);

    // Scenario 4: lose lock in RUN at run_cycles=100, then relock.
    cnt = 0;
    while (m_run < 100 && cnt < 300) begin
      step();
      cnt++;
    end
    check("run_100", bus.run_cycles, 100);
    dcm_locked = 1'b0;
    cnt = 0;
    while (bus.interconnect_aresetn && cnt < 20) begin
      step();
      cnt++;
    end
    check("fault_lat", cnt, S + 1);
    check("fault_per", bus.peripheral_aresetn, 0);
    check("fault_evt", bus.reset_events, 1);
    repeat (10) step();
    check("run_hold", bus.run_cycles, 100 + S + 1);
    dcm_locked = 1'b1;
    run_until(4, 200, "relock_run");

    // Scenario 5: 300 aux pulses from RUN, events saturate.
    for (int i = 0; i < 300; i++) begin
      run_until(4, 200, "aux_to_run");
      aux_reset_in = 1'b1;
      repeat (3) step();
      aux_reset_in = 1'b0;
      if (i == 0) check("aux_evt_first", bus.reset_events, 2);
    end
    repeat (5) step();
    check("evt_sat", bus.reset_events, 255);

    // Scenario 6: async reset in ICN_UP, then long RUN on the narrow counter.
    run_until(3, 200, "to_icn_up");
    do_reset();
    check("async_icn", bus.interconnect_aresetn, 0);
    check("async_evt", bus.reset_events, 0);
    check("async_run", bus.run_cycles, 0);
    check("async_state", bus.seq_state, 0);
    release_rst();
    repeat (S + 2 + F + D + 40) step();
    check("run4_sat", bus4.run_cycles, 15);
    check("run32_long", bus.run_cycles, 40);

    // Random phase.
    for (int i = 0; i < 4000; i++) begin
      if (dcm_locked) begin
        if ($urandom_range(0, 79) == 0) dcm_locked = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        dcm_locked = 1'b1;
      end
      aux_reset_in = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
        release_rst();
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pl_rst_sequencer.md
Name: pl_rst_sequencer

Overview:
- Consumes the CIPS PL clock and the CIPS PL reset and produces the ordered platform resets for the PL fabric.
- Release order is interconnect first, then peripherals.
- Release is gated by a filtered clock-wizard locked indication.
- Exposes sequencer state, a run-cycle counter and a reset-event counter, so simulation and on-board debug can poll reset status directly.

Parameters:
- SYNC_STAGES, 2, depth of the reset-release synchroniser, the locked synchroniser and the aux synchroniser (legal 2..4).
- FILTER_CYCLES, 16, consecutive cycles dcm_locked must stay high before release (legal 1..255).
- ICN_DELAY, 8, cycles between interconnect release and peripheral release (legal 1..255).
- CNT_W, 32, width of run_cycles.

Ports:
- pl_clk0 in 1: CIPS PL clock; the only clock.
- pl_resetn in 1: asynchronous, active-low reset from CIPS.
- dcm_locked in 1: clock-wizard locked; asynchronous to pl_clk0.
- aux_reset_in in 1: active-high software/debug reset request; asynchronous.
- interconnect_aresetn out 1: active-low reset for the AXI interconnect.
- peripheral_aresetn out 1: active-low reset for PL peripherals.
- peripheral_reset out 1: active-high copy of the peripheral reset.
- rst_active out 1: high whenever peripherals are held in reset.
- seq_state out 3: current FSM state encoding.
- run_cycles out CNT_W: pl_clk0 cycles spent in RUN; saturating.
- reset_events out 8: count of fault-triggered re-resets; saturating.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (pl_resetn). Assertion clears every flop immediately, without a clock.
  - Reset values: interconnect_aresetn=0, peripheral_aresetn=0, peripheral_reset=1, rst_active=1, seq_state=RESET_HOLD, run_cycles=0, reset_events=0.
  - All synchronisers are cleared to 0.
- Release of pl_resetn is synchronised. The internal rst_ok goes to 1 after SYNC_STAGES pl_clk0 edges.
- dcm_locked and aux_reset_in each pass through their own SYNC_STAGES-flop synchroniser, reset by pl_resetn. Their outputs are locked_s and aux_s.
- All outputs are registered. There is no combinational path from any input to any output except the asynchronous clear.
- FSM states and transitions:
  - RESET_HOLD: go to WAIT_LOCK when rst_ok=1 and aux_s=0.
  - WAIT_LOCK: if aux_s=1, go to RESET_HOLD. Else if locked_s=1, go to FILTER with filt_cnt=0.
  - FILTER: if aux_s=1, go to RESET_HOLD. Else if locked_s=0, go to WAIT_LOCK. Else filt_cnt increments.
    - At the edge where filt_cnt==FILTER_CYCLES-1, go to ICN_UP, load dly_cnt=0, and set interconnect_aresetn=1 at that same edge.
  - ICN_UP: dly_cnt increments.
    - At the edge where dly_cnt==ICN_DELAY-1, go to RUN and at that same edge set peripheral_aresetn=1, peripheral_reset=0, rst_active=0.
  - RUN: run_cycles increments every edge and saturates at all-ones.
  - Fault in ICN_UP or RUN (locked_s=0 or aux_s=1): go to RESET_HOLD at the next edge.
    - At that same edge, drive all reset outputs back to asserted values and increment reset_events (saturate at 255).
    - run_cycles holds its value; it is not cleared.
  - Exits from WAIT_LOCK or FILTER to RESET_HOLD do not count as events.
- Default latency, with dcm_locked high before pl_resetn release and aux low (edge 1 = first pl_clk0 rising edge after release):
  - rst_ok=1 after edge 2; WAIT_LOCK at edge 3; FILTER at edge 4.
  - interconnect_aresetn rises at edge 20.
  - peripheral_aresetn rises at edge 28.
  - run_cycles=1 after edge 29.
- Simultaneous aux_s=1 and locked_s=0: treated as a single fault, so one event is counted.
- Glitch on dcm_locked during FILTER: the filter restarts from 0 via WAIT_LOCK, and reset outputs never toggle.
- pl_resetn asserted mid-sequence: immediate asynchronous return to reset values, including both counters.

Decomposition:
- Package pl_rst_pkg holds:
  - the state enum: RESET_HOLD=0, WAIT_LOCK=1, FILTER=2, ICN_UP=3, RUN=4;
  - the STATE_W=3 constant;
  - the counter saturation helper constants.
- One sub-module, pl_rst_sync: a parameterised SYNC_STAGES flop chain with asynchronous active-low clear. It is instantiated three times: reset release, locked and aux.

Test Plan:
- Locked high, release pl_resetn:
  - interconnect_aresetn rises at edge 20 and peripheral_aresetn at edge 28.
  - peripheral_reset falls at edge 28.
  - seq_state reads 0,1,2,3,4 at the documented edges.
- dcm_locked low for 40 cycles after release, then high: interconnect_aresetn rises 16+SYNC_STAGES+1 edges after the locked rise. reset_events=0.
- dcm_locked pulsed low for 1 cycle at filt_cnt=10: the filter restarts, release is delayed accordingly, and no output glitch occurs.
- In RUN at run_cycles=100, drop dcm_locked:
  - All resets assert SYNC_STAGES+1 edges later and reset_events=1.
  - run_cycles holds at its final value.
  - On relock, the full sequence repeats.
- aux_reset_in pulsed 3 cycles in RUN, then 300 such faults: each counted once, and reset_events saturates at 255.
- Assert pl_resetn during ICN_UP, then use CNT_W=4 with a long RUN:
  - Asserting pl_resetn clears all outputs and counters with no clock.
  - With CNT_W=4, run_cycles saturates at 15.
